// File: rtl/dbus_arbiter_if.sv
// Generic data-bus channel: one requester-to-slave transfer path.
// The requester drives master; the slave side (or the arbiter facing a requester) uses slave.
interface dbus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            req;
   logic [AW-1:0]   addr;
   logic            we;
   logic [DW/8-1:0] wstrb;
   logic [DW-1:0]   wdata;
   logic            ack;
   logic            err;
   logic [DW-1:0]   rdata;

   modport master (output req, addr, we, wstrb, wdata, input ack, err, rdata);
   modport slave  (input req, addr, we, wstrb, wdata, output ack, err, rdata);
endinterface

// File: rtl/dbus_arbiter.sv
// Two-requester round-robin arbiter onto one shared slave, with a per-transfer
// wait timeout that returns a bus error when the slave never acknowledges.
module dbus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   dbus_arbiter_if.slave  m0,
   dbus_arbiter_if.slave  m1,
   dbus_arbiter_if.master s
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t          state, state_nxt;
   logic            last_grant, last_grant_nxt;
   logic            grant0, grant1, done;
   logic [7:0]      wait_cnt;
   logic            req_q;
   logic [AW-1:0]   addr_q;
   logic            we_q;
   logic [DW/8-1:0] wstrb_q;
   logic [DW-1:0]   wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // last_grant=1 means m1 finished most recently, so m0 wins the next tie.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      grant0         = 1'b0;
      grant1         = 1'b0;
      done           = 1'b0;
      case (state)
         IDLE: begin
            if (m0.req && (!m1.req || last_grant)) begin
               grant0    = 1'b1;
               state_nxt = BUSY0;
            end else if (m1.req) begin
               grant1    = 1'b1;
               state_nxt = BUSY1;
            end
         end
         BUSY0, BUSY1: begin
            if (s.ack || (wait_cnt == TIMEOUT_CNT)) begin
               done           = 1'b1;
               state_nxt      = IDLE;
               last_grant_nxt = (state == BUSY1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q    <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wstrb_q  <= '0;
         wdata_q  <= '0;
         wait_cnt <= '0;
      end else if (grant0) begin
         req_q    <= 1'b1;
         addr_q   <= m0.addr;
         we_q     <= m0.we;
         wstrb_q  <= m0.wstrb;
         wdata_q  <= m0.wdata;
         wait_cnt <= '0;
      end else if (grant1) begin
         req_q    <= 1'b1;
         addr_q   <= m1.addr;
         we_q     <= m1.we;
         wstrb_q  <= m1.wstrb;
         wdata_q  <= m1.wdata;
         wait_cnt <= '0;
      end else if (done) begin
         req_q <= 1'b0;
      end else if (state != IDLE) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign s.req   = req_q;
   assign s.addr  = addr_q;
   assign s.we    = we_q;
   assign s.wstrb = wstrb_q;
   assign s.wdata = wdata_q;

   // A real slave ack beats a coincident timeout; a timeout alone reports err with zero data.
   assign m0.ack   = (state == BUSY0) && done;
   assign m1.ack   = (state == BUSY1) && done;
   assign m0.err   = m0.ack && (s.ack ? s.err : 1'b1);
   assign m1.err   = m1.ack && (s.ack ? s.err : 1'b1);
   assign m0.rdata = (m0.ack && s.ack) ? s.rdata : '0;
   assign m1.rdata = (m1.ack && s.ack) ? s.rdata : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: stimulus pushes expected acks into a
// scoreboard queue that an independent negedge monitor pops and compares.
module tb_dbus_arbiter;

   typedef struct {
      bit          port;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   logic clk;
   logic rst_n;
   int   assertCount = 0;
   int   failCount   = 0;
   exp_t expQ[$];

   dbus_arbiter_if #(.AW(32), .DW(32)) m0if ();
   dbus_arbiter_if #(.AW(32), .DW(32)) m1if ();
   dbus_arbiter_if #(.AW(32), .DW(32)) sif ();

   dbus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (m0if),
      .m1    (m1if),
      .s     (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit port, input bit req, input logic [31:0] addr,
                                input bit we, input logic [3:0] wstrb, input logic [31:0] wdata);
      if (port) begin
         m1if.req = req; m1if.addr = addr; m1if.we = we; m1if.wstrb = wstrb; m1if.wdata = wdata;
      end else begin
         m0if.req = req; m0if.addr = addr; m0if.we = we; m0if.wstrb = wstrb; m0if.wdata = wdata;
      end
   endtask

   task automatic slaveDrive(input bit ack, input bit err, input logic [31:0] rdata);
      sif.ack = ack; sif.err = err; sif.rdata = rdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input bit port, input bit err, input logic [31:0] rdata);
      exp_t e;
      e.port = port; e.err = err; e.rdata = rdata;
      expQ.push_back(e);
   endtask

   // Monitor: every ack must match the oldest expectation; otherwise all master outputs stay zero.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (m0if.ack || m1if.ack) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_ack", {m0if.ack, m1if.ack}, 2'b00);
            end else begin
               e = expQ.pop_front();
               checkOutput("ack_owner", {m0if.ack, m1if.ack}, e.port ? 2'b01 : 2'b10);
               checkOutput("ack_err", e.port ? m1if.err : m0if.err, e.err);
               checkOutput("ack_rdata", e.port ? m1if.rdata : m0if.rdata, e.rdata);
               checkOutput("nonowner_zero", e.port ? {m0if.err, m0if.rdata} : {m1if.err, m1if.rdata}, 0);
            end
         end else begin
            checkOutput("quiet_zero", {m0if.err, m1if.err, m0if.rdata, m1if.rdata}, 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      slaveDrive(0, 0, 0);
      tick();
      checkOutput("rst_sreq", sif.req, 0);
      checkOutput("rst_sfields", {sif.addr, sif.we, sif.wstrb, sif.wdata}, 0);
      checkOutput("rst_acks", {m0if.ack, m1if.ack}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single m0 read, slave acks in the second busy cycle
      applyStimulus(0, 1, 32'h1000_0004, 0, 4'h0, 0);
      checkOutput("t1_sreq_before", sif.req, 0);
      tick();
      checkOutput("t1_sreq", sif.req, 1);
      checkOutput("t1_saddr", sif.addr, 32'h1000_0004);
      checkOutput("t1_swe", sif.we, 0);
      tick();
      slaveDrive(1, 0, 32'hDEAD_BEEF);
      pushExp(0, 0, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      slaveDrive(0, 0, 0);
      checkOutput("t1_sreq_drop", sif.req, 0);

      // Fresh reset, then both requesters hammer: grants must alternate m0,m1,m0,m1
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(0, 1, 32'h0000_0100, 0, 0, 0);
      applyStimulus(1, 1, 32'h0000_0200, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("t2_grant_addr", sif.addr, (i % 2) ? 32'h200 : 32'h100);
         slaveDrive(1, 0, 32'h50 + i);
         pushExp(i % 2, 0, 32'h50 + i);
         tick();
         slaveDrive(0, 0, 0);
         checkOutput("t2_sreq_drop", sif.req, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();

      // m1 write whose fields change mid-transfer; latched copy must hold
      applyStimulus(1, 1, 32'h4000_0000, 1, 4'h1, 32'h0000_00A5);
      tick();
      applyStimulus(1, 1, 32'h0, 1, 4'h1, 32'h0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("t3_hold", {sif.req, sif.addr, sif.we, sif.wstrb, sif.wdata},
                     {1'b1, 32'h4000_0000, 1'b1, 4'h1, 32'h0000_00A5});
         if (k < 2) tick();
      end
      slaveDrive(1, 0, 0);
      pushExp(1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();
      slaveDrive(0, 0, 0);
      checkOutput("t3_sreq_drop", sif.req, 0);

      // Slave never acks m0: error ack on the fifth busy cycle (counter reached 4)
      sif.rdata = 32'hBAD0_BAD0;
      applyStimulus(0, 1, 32'h0000_2000, 0, 0, 0);
      tick();
      pushExp(0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         checkOutput("t4_wait", m0if.ack, 0);
         tick();
      end
      checkOutput("t4_timeout", m0if.ack, 1);
      tick();
      checkOutput("t4_sreq_drop", sif.req, 0);
      applyStimulus(1, 1, 32'h0000_3000, 0, 0, 0);
      tick();
      checkOutput("t4_m1_saddr", sif.addr, 32'h3000);
      slaveDrive(1, 0, 32'h1234_5678);
      pushExp(1, 0, 32'h1234_5678);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();
      slaveDrive(0, 0, 0);

      // Reset in the middle of an m0 transfer; a late slave ack is ignored
      applyStimulus(0, 1, 32'h0000_5000, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_sreq", sif.req, 0);
      checkOutput("t5_rst_saddr", sif.addr, 0);
      checkOutput("t5_rst_ack", {m0if.ack, m1if.ack}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      slaveDrive(1, 0, 32'h77);
      checkOutput("t5_late_ack", {m0if.ack, m1if.ack}, 0);
      tick();
      slaveDrive(0, 0, 0);
      checkOutput("t5_idle_sreq", sif.req, 0);

      // m1 read returning a slave error passes err and data through
      applyStimulus(1, 1, 32'h0000_6000, 0, 0, 0);
      tick();
      slaveDrive(1, 1, 32'hCAFE_F00D);
      pushExp(1, 1, 32'hCAFE_F00D);
      applyStimulus(1, 0, 0, 0, 0, 0);
      tick();
      slaveDrive(0, 0, 0);
      tick();
      tick();

      checkOutput("sb_drained", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
